// File: rtl/timer_pkg.sv
// Shared types and constants for the countdown timer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } timer_state_t;

    localparam logic [3:0] BCD_MAX      = 4'd9;
    localparam logic [3:0] SEC_TENS_MAX = 4'd5;

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD down-counting digit with a configurable wrap value; the instances chain by borrow.
// Latency: load and decrement are visible one cycle after they are sampled.
// Backpressure: none; dec_en is acted on in the cycle it is presented.
//
// Ports: clk, reset (sync, active-high), load/load_digit (clamped to max_value on capture),
//        dec_en (decrement this cycle), max_value (wrap target and clamp limit),
//        digit (current value), borrow_out (this digit wraps on the current decrement).
module bcd_down_digit (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] load_digit,
    input  logic       dec_en,
    input  logic [3:0] max_value,
    output logic [3:0] digit,
    output logic       borrow_out
);

    always_ff @(posedge clk) begin
        if (reset) begin
            digit <= 4'd0;
        end else if (load) begin
            // Out-of-range inputs are clamped so the segment decoder never sees an illegal code.
            digit <= (load_digit > max_value) ? max_value : load_digit;
        end else if (dec_en) begin
            digit <= (digit == 4'd0) ? max_value : digit - 4'd1;
        end
    end

    assign borrow_out = dec_en && (digit == 4'd0);

endmodule

// File: rtl/bcd_countdown_core.sv
// MM:SS BCD countdown timer: FSM, one-second prescaler and four chained BCD digits.
// Latency: commands take effect at the next edge; decrements every TICK_DIV cycles in RUN.
// Backpressure: none; commands are level inputs resolved reset > load > stop > start.
//
// Ports: clk, reset (sync, active-high), load/load_value (BCD MM:SS), start, stop,
//        min_tens/min_ones/sec_tens/sec_ones (current BCD digits),
//        running (in RUN), expired (in DONE), done_pulse (one cycle on entry to DONE).
module bcd_countdown_core
    import timer_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] load_value,
    input  logic        start,
    input  logic        stop,
    output logic [3:0]  min_tens,
    output logic [3:0]  min_ones,
    output logic [3:0]  sec_tens,
    output logic [3:0]  sec_ones,
    output logic        running,
    output logic        expired,
    output logic        done_pulse
);

    localparam int            PW         = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    timer_state_t  state;
    timer_state_t  state_nxt;
    logic [PW-1:0] presc;
    logic          tick;
    logic          dec;
    logic          is_zero;
    logic          is_one;
    logic          b_so;
    logic          b_st;
    logic          b_mo;
    logic          borrow_unused;

    assign is_zero = ({min_tens, min_ones, sec_tens, sec_ones} == 16'h0000);
    assign is_one  = ({min_tens, min_ones, sec_tens, sec_ones} == 16'h0001);

    assign tick = (state == RUN) && (presc == PRESC_LAST);
    // load and stop both outrank the tick: the second is consumed but nothing decrements.
    assign dec  = tick && !load && !stop;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        if (load) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE:    if (!stop && start && !is_zero) state_nxt = RUN;
                RUN: begin
                    if (stop)                 state_nxt = PAUSE;
                    else if (tick && is_one)  state_nxt = DONE;
                end
                PAUSE:   if (!stop && start)  state_nxt = RUN;
                DONE:    state_nxt = DONE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Output decode
    always_comb begin
        running = (state == RUN);
        expired = (state == DONE);
    end

    // The prescaler counts every cycle spent in RUN, including the cycle in which stop is
    // sampled, so a resume only waits out the remainder of the interrupted second.
    always_ff @(posedge clk) begin
        if (reset || load || state == IDLE) begin
            presc <= '0;
        end else if (state == RUN) begin
            presc <= tick ? '0 : presc + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            done_pulse <= 1'b0;
        end else begin
            done_pulse <= dec && is_one;
        end
    end

    bcd_down_digit u_sec_ones (
        .clk(clk), .reset(reset), .load(load), .load_digit(load_value[3:0]),
        .dec_en(dec), .max_value(BCD_MAX), .digit(sec_ones), .borrow_out(b_so)
    );

    bcd_down_digit u_sec_tens (
        .clk(clk), .reset(reset), .load(load), .load_digit(load_value[7:4]),
        .dec_en(b_so), .max_value(SEC_TENS_MAX), .digit(sec_tens), .borrow_out(b_st)
    );

    bcd_down_digit u_min_ones (
        .clk(clk), .reset(reset), .load(load), .load_digit(load_value[11:8]),
        .dec_en(b_st), .max_value(BCD_MAX), .digit(min_ones), .borrow_out(b_mo)
    );

    // min_tens never borrows: a decrement only happens while the value is non-zero.
    bcd_down_digit u_min_tens (
        .clk(clk), .reset(reset), .load(load), .load_digit(load_value[15:12]),
        .dec_en(b_mo), .max_value(BCD_MAX), .digit(min_tens), .borrow_out(borrow_unused)
    );

endmodule

// File: tb/tb_bcd_countdown_core.sv
// Bench for bcd_countdown_core: directed scenarios then random commands, checked by a scoreboard.
// Latency: expected snapshot per cycle is compared just after the edge it predicts.
// Backpressure: none.
module tb_bcd_countdown_core;

    localparam int TD = 4;
    localparam int P_IDLE = 0, P_RUN = 1, P_PAUSE = 2, P_DONE = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load = 1'b0;
    logic [15:0] load_value = 16'h0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [3:0]  min_tens, min_ones, sec_tens, sec_ones;
    logic        running, expired, done_pulse;

    always #5 clk = ~clk;

    bcd_countdown_core #(.TICK_DIV(TD)) dut (
        .clk(clk), .reset(reset), .load(load), .load_value(load_value),
        .start(start), .stop(stop),
        .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
        .running(running), .expired(expired), .done_pulse(done_pulse)
    );

    typedef struct packed {
        logic [15:0] digits;
        logic        running;
        logic        expired;
        logic        pulse;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    // Reference model: remaining time in plain seconds, cycles counted toward the next second.
    int m_secs  = 0;
    int m_cnt   = 0;
    int m_phase = P_IDLE;

    function automatic int clampd(input int d, input int mx);
        return (d > mx) ? mx : d;
    endfunction

    task automatic cyc(input logic r, input logic l, input logic [15:0] lv,
                       input logic st, input logic sp);
        exp_t e;
        logic pulse;
        int   mins, secs;
        @(negedge clk);
        reset = r; load = l; load_value = lv; start = st; stop = sp;
        pulse = 1'b0;
        if (r) begin
            m_secs = 0; m_cnt = 0; m_phase = P_IDLE;
        end else if (l) begin
            mins   = clampd(int'(lv[15:12]), 9) * 10 + clampd(int'(lv[11:8]), 9);
            secs   = clampd(int'(lv[7:4]), 5) * 10 + clampd(int'(lv[3:0]), 9);
            m_secs = mins * 60 + secs;
            m_cnt  = 0; m_phase = P_IDLE;
        end else begin
            case (m_phase)
                P_IDLE:  if (!sp && st && m_secs != 0) m_phase = P_RUN;
                P_RUN: begin
                    logic fire;
                    fire = (m_cnt == TD - 1);
                    m_cnt = fire ? 0 : m_cnt + 1;
                    if (sp) begin
                        m_phase = P_PAUSE;
                    end else if (fire) begin
                        m_secs = m_secs - 1;
                        if (m_secs == 0) begin
                            m_phase = P_DONE;
                            pulse = 1'b1;
                        end
                    end
                end
                P_PAUSE: if (!sp && st) m_phase = P_RUN;
                default: ;
            endcase
        end
        mins = m_secs / 60;
        secs = m_secs % 60;
        e.digits  = {4'(mins / 10), 4'(mins % 10), 4'(secs / 10), 4'(secs % 10)};
        e.running = (m_phase == P_RUN);
        e.expired = (m_phase == P_DONE);
        e.pulse   = pulse;
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    endtask

    task automatic do_load(input logic [15:0] v);
        cyc(1'b0, 1'b1, v, 1'b0, 1'b0);
    endtask

    task automatic do_start();
        cyc(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
    endtask

    task automatic do_stop();
        cyc(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
    endtask

    // Monitor: every edge the DUT presents a new snapshot; compare against the oldest prediction.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                mon_e = q.pop_front();
                checks++;
                if ({min_tens, min_ones, sec_tens, sec_ones} !== mon_e.digits) begin
                    errors++;
                    $display("FAIL digits at %0t: got %h want %h", $time,
                             {min_tens, min_ones, sec_tens, sec_ones}, mon_e.digits);
                end
                checks++;
                if ({running, expired, done_pulse} !== {mon_e.running, mon_e.expired, mon_e.pulse}) begin
                    errors++;
                    $display("FAIL flags(run,exp,pulse) at %0t: got %b%b%b want %b%b%b", $time,
                             running, expired, done_pulse,
                             mon_e.running, mon_e.expired, mon_e.pulse);
                end
            end
        end
    end

    initial begin
        logic        r, l, st, sp;
        logic [15:0] lv;

        // Reset, then start with 00:00 must stay idle.
        cyc(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
        do_start();
        idle(3);

        // Borrow chain through every digit.
        do_load(16'h1000);
        do_start();
        idle(10);

        // Expiry, single-cycle pulse, start ignored in DONE.
        do_load(16'h0002);
        do_start();
        idle(10);
        do_start();
        idle(3);

        // Pause after two counted cycles, long freeze, resume.
        do_load(16'h0010);
        do_start();
        idle(1);
        do_stop();
        idle(20);
        do_start();
        idle(4);

        // Sanitised load.
        do_load(16'hAF7C);
        idle(2);

        // stop on the tick cycle, then load on a later tick cycle.
        do_load(16'h0005);
        do_start();
        idle(3);
        do_stop();
        idle(2);
        do_start();
        idle(3);
        do_load(16'h0030);
        idle(3);

        // Random commands.
        for (int i = 0; i < 3000; i++) begin
            r  = ($urandom_range(0, 199) == 0);
            l  = ($urandom_range(0, 29) == 0);
            lv = ($urandom_range(0, 1) == 1) ? 16'($urandom)
                                             : {8'h00, 4'($urandom_range(0, 1)), 4'($urandom)};
            st = ($urandom_range(0, 3) == 0);
            sp = ($urandom_range(0, 15) == 0);
            cyc(r, l, lv, st, sp);
        end

        @(posedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard drain: got %0d pending want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
